rv32i_encoder_loader: RTL and testbench

- Inverse of the team's RV32I instruction decoder.
- Accepts instruction fields (format, opcode, funct3, funct7, rd, rs1, rs2, 32-bit immediate) over a valid/ready handshake and packs them into a standard RV32I 32-bit word.
- Buffers encoded words in a small FIFO and writes them to sequential word addresses of instruction memory.
- Used as the program loader and test-program generator for the processor.

---
 rtl/rv32i_pkg.sv | 47 ++++
 rtl/sync_fifo.sv | 54 +++++
 rtl/rv32i_encoder_loader.sv | 136 +++++++++++++
 tb/tb_rv32i_encoder_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
//------------------------------------------------------------------------------
// rv32i_pkg : RV32I format, opcode and funct constants shared with the decoder
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Immediate shifts carry funct7 in the upper bits and a 5-bit shamt.
  function automatic logic is_shift_imm(input logic [6:0] op, input logic [2:0] f3);
    return (op == OP_IMM) && ((f3 == F3_SLL) || (f3 == F3_SRL_SRA));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// sync_fifo : single-clock FIFO, power-of-two depth, flush has priority
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/rv32i_encoder_loader.sv
//------------------------------------------------------------------------------
// rv32i_encoder_loader : packs RV32I fields into words and streams them to imem
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rv32i_encoder_loader
  import rv32i_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [15:0]       words_written,
  output logic              err,
  output logic [7:0]        err_count,
  output logic              busy
);

  logic [31:0]       enc_word;
  logic              reject;
  logic              shift_form;
  logic              fits_i12;
  logic              fits_b13;
  logic              fits_j21;
  logic              fits_shamt;
  logic              accept;
  logic              push;
  logic              pop;
  logic              bad_bundle;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       fifo_head;
  logic [ADDR_W-1:0] addr;

  // Sign-extension tests: every bit above the field's sign bit must match it.
  assign fits_i12   = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits_b13   = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits_j21   = (imm[31:20] == '0) || (imm[31:20] == '1);
  assign fits_shamt = (imm[31:5] == '0);
  assign shift_form = is_shift_imm(opcode, funct3);

  always_comb begin
    enc_word = '0;
    reject   = 1'b0;
    case (fmt)
      FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if (shift_form) begin
          enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          reject   = !fits_shamt;
        end else begin
          enc_word = {imm[11:0], rs1, funct3, rd, opcode};
          reject   = !fits_i12;
        end
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        reject   = !fits_i12;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        reject   = !fits_b13 || imm[0];
      end
      FMT_U: enc_word = {imm[31:12], rd, opcode};
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        reject   = !fits_j21 || imm[0];
      end
      default: reject = 1'b1;
    endcase
  end

  assign in_ready   = !fifo_full;
  assign accept     = in_valid && in_ready && !start;
  assign push       = accept && !reject;
  assign bad_bundle = accept && reject;
  assign imem_we    = !fifo_empty;
  assign pop        = imem_we && imem_ready && !start;
  assign busy       = !fifo_empty;
  assign imem_addr  = addr;
  assign imem_wdata = fifo_empty ? 32'h0 : fifo_head;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .push  (push),
    .pop   (pop),
    .wdata (enc_word),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst || start) begin
      addr          <= BASE_ADDR;
      words_written <= '0;
      err           <= 1'b0;
      err_count     <= '0;
    end else begin
      if (pop) begin
        addr          <= addr + ADDR_W'(4);
        words_written <= words_written + 16'd1;
      end
      if (bad_bundle) begin
        err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_encoder_loader.sv
//------------------------------------------------------------------------------
// tb_rv32i_encoder_loader : vector table, corner sequences and random stimulus
// Revision                : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rv32i_encoder_loader;

  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } bundle_t;

  typedef struct {
    bundle_t     b;
    bit          rej;
    logic [31:0] word;
  } vec_t;

  logic        clk, rst, start, in_valid, in_ready, imem_we, imem_ready, err, busy;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, imem_addr, imem_wdata;
  logic [15:0] words_written;
  logic [7:0]  err_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  rv32i_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
    .rs1(rs1), .rs2(rs2), .imm(imm), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .words_written(words_written),
    .err(err), .err_count(err_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: encodings written straight from the field layouts.
  function automatic logic [31:0] m_encode(input bundle_t b);
    bit sh = (b.op == 7'b0010011) && (b.f3 == 3'd1 || b.f3 == 3'd5);
    case (b.fmt)
      3'd0: return {b.f7, b.rs2, b.rs1, b.f3, b.rd, b.op};
      3'd1: return sh ? {b.f7, b.imm[4:0], b.rs1, b.f3, b.rd, b.op}
                      : {b.imm[11:0], b.rs1, b.f3, b.rd, b.op};
      3'd2: return {b.imm[11:5], b.rs2, b.rs1, b.f3, b.imm[4:0], b.op};
      3'd3: return {b.imm[12], b.imm[10:5], b.rs2, b.rs1, b.f3, b.imm[4:1], b.imm[11], b.op};
      3'd4: return {b.imm[31:12], b.rd, b.op};
      3'd5: return {b.imm[20], b.imm[10:1], b.imm[11], b.imm[19:12], b.rd, b.op};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_reject(input bundle_t b);
    longint s  = longint'($signed(b.imm));
    bit     sh = (b.op == 7'b0010011) && (b.f3 == 3'd1 || b.f3 == 3'd5);
    case (b.fmt)
      3'd0, 3'd4: return 1'b0;
      3'd1: return sh ? !(s >= 0 && s <= 31) : !(s >= -2048 && s <= 2047);
      3'd2: return !(s >= -2048 && s <= 2047);
      3'd3: return !(s >= -4096 && s <= 4094) || (s % 2 != 0);
      3'd5: return !(s >= -1048576 && s <= 1048574) || (s % 2 != 0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bundle_t mk(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [31:0] im);
    bundle_t b;
    b.fmt = f; b.op = op; b.f3 = f3; b.f7 = f7; b.rd = d; b.rs1 = s1; b.rs2 = s2; b.imm = im;
    return b;
  endfunction

  // Scoreboard tracking queue contents, address and counters cycle by cycle.
  logic [31:0] exp_q[$];
  logic [31:0] m_addr;
  logic [15:0] m_ww;
  logic [7:0]  m_errc;
  bit          m_err;
  bit          chk_en = 1'b0;

  always @(negedge clk) begin
    bundle_t cur;
    bit      acc, pp;
    if (chk_en) begin
      chk("mon_in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < DEPTH});
      chk("mon_imem_we", {31'd0, imem_we}, {31'd0, exp_q.size() > 0});
      chk("mon_busy", {31'd0, busy}, {31'd0, exp_q.size() > 0});
      chk("mon_addr", imem_addr, m_addr);
      chk("mon_wdata", imem_wdata, (exp_q.size() > 0) ? exp_q[0] : 32'h0);
      chk("mon_words_written", {16'd0, words_written}, {16'd0, m_ww});
      chk("mon_err", {31'd0, err}, {31'd0, m_err});
      chk("mon_err_count", {24'd0, err_count}, {24'd0, m_errc});
    end
    if (rst || start) begin
      exp_q.delete();
      m_addr = BASE; m_ww = '0; m_errc = '0; m_err = 1'b0;
      if (rst) chk_en = 1'b1;
    end else if (chk_en) begin
      cur = mk(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
      acc = in_valid && (exp_q.size() < DEPTH);
      pp  = (exp_q.size() > 0) && imem_ready;
      if (pp) begin
        void'(exp_q.pop_front());
        m_addr += 32'd4;
        m_ww   += 16'd1;
      end
      if (acc) begin
        if (m_reject(cur)) begin
          m_err = 1'b1;
          if (m_errc != 8'hFF) m_errc += 8'd1;
        end else begin
          exp_q.push_back(m_encode(cur));
        end
      end
    end
  end

  task automatic drive(input bundle_t b);
    fmt = b.fmt; opcode = b.op; funct3 = b.f3; funct7 = b.f7;
    rd = b.rd; rs1 = b.rs1; rs2 = b.rs2; imm = b.imm;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns likewise, just after the accept edge.
  task automatic send(input bundle_t b);
    bit got = 1'b0;
    int n   = 0;
    drive(b);
    in_valid = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: bundle not accepted within %0d cycles", n);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  function automatic bundle_t rand_bundle();
    logic [31:0] bnd [18] = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd31, 32'd32,
                              32'd4094, 32'd4095, 32'd4096, -32'sd4096, -32'sd4098,
                              32'd1048574, 32'd1048575, 32'd1048576, -32'sd1048576,
                              -32'sd1048578, 32'd0, 32'hFFFF_FFFF};
    logic [6:0]  iops [3] = '{7'b0010011, 7'b0000011, 7'b1100111};
    bundle_t b;
    b.fmt = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    case (b.fmt)
      3'd0: b.op = 7'b0110011;
      3'd1: b.op = iops[$urandom_range(0, 2)];
      3'd2: b.op = 7'b0100011;
      3'd3: b.op = 7'b1100011;
      3'd4: b.op = $urandom_range(0, 1) ? 7'b0110111 : 7'b0010111;
      3'd5: b.op = 7'b1101111;
      default: b.op = 7'($urandom);
    endcase
    b.f3  = 3'($urandom);
    b.f7  = $urandom_range(0, 1) ? 7'b0100000 : 7'($urandom);
    b.rd  = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    case ($urandom_range(0, 3))
      0: b.imm = 32'($urandom_range(0, 80)) - 32'd40;
      1: b.imm = bnd[$urandom_range(0, 17)];
      2: b.imm = $urandom;
      default: b.imm = 32'($urandom_range(0, 40));
    endcase
    return b;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [31:0] exp_addr;
    logic [7:0]  rejcnt;
    bundle_t     b5;

    vecs.push_back('{mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5), 1'b0, 32'h00500093});
    vecs.push_back('{mk(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0), 1'b0, 32'h002081B3});
    vecs.push_back('{mk(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8), 1'b0, 32'h0020A423});
    vecs.push_back('{mk(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4), 1'b0, 32'hFE208EE3});
    vecs.push_back('{mk(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8), 1'b0, 32'h008000EF});
    vecs.push_back('{mk(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000), 1'b0, 32'h123452B7});
    vecs.push_back('{mk(3'd1, 7'b0010011, 3'd1, 7'd0, 5'd1, 5'd1, 5'd0, 32'd31), 1'b0, 32'h01F09093});
    vecs.push_back('{mk(3'd1, 7'b0010011, 3'd1, 7'd0, 5'd1, 5'd1, 5'd0, 32'd32), 1'b1, 32'h0});
    vecs.push_back('{mk(3'd1, 7'b0010011, 3'd5, 7'b0100000, 5'd1, 5'd1, 5'd0, 32'd3), 1'b0, 32'h4030D093});
    vecs.push_back('{mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2047), 1'b0, 32'h7FF00013});
    vecs.push_back('{mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048), 1'b1, 32'h0});
    vecs.push_back('{mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd2049), 1'b1, 32'h0});
    vecs.push_back('{mk(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd2048), 1'b0, 32'h80002023});
    vecs.push_back('{mk(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4094), 1'b0, 32'h7E000FE3});
    vecs.push_back('{mk(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd6), 1'b0, 32'h00000363});
    vecs.push_back('{mk(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5), 1'b1, 32'h0});
    vecs.push_back('{mk(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3), 1'b1, 32'h0});
    vecs.push_back('{mk(3'd7, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0), 1'b1, 32'h0});

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; imem_ready = 1'b0;
    drive(mk(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0));
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_imem_we", {31'd0, imem_we}, 32'd0);
    chk("reset_addr", imem_addr, BASE);
    chk("reset_wdata", imem_wdata, 32'd0);
    chk("reset_err_count", {24'd0, err_count}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    cyc(1);

    // Vector table, one bundle at a time with the memory always ready.
    imem_ready = 1'b1;
    exp_addr   = BASE;
    rejcnt     = '0;
    foreach (vecs[i]) begin
      send(vecs[i].b);
      @(negedge clk);
      if (vecs[i].rej) begin
        rejcnt++;
        chk($sformatf("vec%0d_err_count", i), {24'd0, err_count}, {24'd0, rejcnt});
        chk($sformatf("vec%0d_no_write", i), {31'd0, imem_we}, 32'd0);
      end else begin
        chk($sformatf("vec%0d_we", i), {31'd0, imem_we}, 32'd1);
        chk($sformatf("vec%0d_word", i), imem_wdata, vecs[i].word);
        chk($sformatf("vec%0d_addr", i), imem_addr, exp_addr);
        exp_addr += 32'd4;
      end
      cyc(1);
    end

    // Error mix after start: only the even in-range branch is written.
    pulse_start();
    send(mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048));
    send(mk(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd6));
    send(mk(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5));
    send(mk(3'd7, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0));
    cyc(3);
    @(negedge clk);
    chk("errs_err", {31'd0, err}, 32'd1);
    chk("errs_err_count", {24'd0, err_count}, 32'd3);
    chk("errs_words_written", {16'd0, words_written}, 32'd1);
    cyc(1);

    // Backpressure: four fill the FIFO, the fifth waits for space.
    pulse_start();
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      send(mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'(k + 1), 5'd0, 5'd0, 32'(k + 10)));
    b5 = mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd14);
    drive(b5);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_we_held", {31'd0, imem_we}, 32'd1);
      chk("bp_addr_held", imem_addr, BASE);
      chk("bp_wdata_held", imem_wdata, 32'h00A00093);
    end
    cyc(1);
    imem_ready = 1'b1;
    send(b5);
    cyc(8);
    @(negedge clk);
    chk("bp_words_written", {16'd0, words_written}, 32'd5);
    chk("bp_final_addr", imem_addr, BASE + 32'd20);
    chk("bp_drained", {31'd0, busy}, 32'd0);
    cyc(1);

    // start with three words queued plus a prior error.
    imem_ready = 1'b0;
    send(mk(3'd6, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0));
    for (int k = 0; k < 3; k++)
      send(mk(3'd0, 7'b0110011, 3'd0, 7'd0, 5'(k), 5'd1, 5'd2, 32'd0));
    @(negedge clk);
    chk("pre_start_busy", {31'd0, busy}, 32'd1);
    cyc(1);
    pulse_start();
    @(negedge clk);
    chk("start_we", {31'd0, imem_we}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd0);
    chk("start_ww", {16'd0, words_written}, 32'd0);
    chk("start_err", {31'd0, err}, 32'd0);
    chk("start_err_count", {24'd0, err_count}, 32'd0);
    cyc(1);
    imem_ready = 1'b1;
    send(mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5));
    @(negedge clk);
    chk("post_start_addr", imem_addr, BASE);
    chk("post_start_word", imem_wdata, 32'h00500093);
    cyc(1);

    // Reset in the middle of pending writes.
    imem_ready = 1'b0;
    send(mk(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0));
    send(mk(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd4, 5'd1, 5'd2, 32'd0));
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_we", {31'd0, imem_we}, 32'd0);
    chk("rst_mid_addr", imem_addr, BASE);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    cyc(1);

    // Random traffic checked by the scoreboard.
    for (int i = 0; i < 600; i++) begin
      drive(rand_bundle());
      in_valid   = ($urandom_range(0, 2) != 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      start      = ($urandom_range(0, 59) == 0);
      cyc(1);
    end
    start      = 1'b0;
    in_valid   = 1'b0;
    imem_ready = 1'b1;
    cyc(12);
    @(negedge clk);
    chk("final_drained", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
